// File: rtl/ahb_burst_master.sv
// rtl/ahb_burst_master.sv - AHB-Lite burst initiator (SINGLE/INCR4/INCR8/INCR16, word size)
//
// Turns a command (write/read, start address, length code) into one AHB-Lite
// word burst. Write beats are staged in an internal buffer before (or, with
// AHBM_BUSY_EN, while) the burst runs; read beats stream out on rd_valid/rd_data
// without backpressure. done pulses once per command; err qualifies done when
// the burst was cut short by an error response.
//
// Optional feature macro: AHBM_BUSY_EN
//   defined   - a write burst starts after its first beat is buffered and
//               drives HTRANS=BUSY (address held) while the buffer runs dry.
//   undefined - a write burst starts only after all beats are buffered.
//
// Parameters
//   BUF_DEPTH  write staging buffer depth in words (>= 16)
//   RD_PIPE    1 = rd_valid/rd_data delayed by one register stage
//
// Ports
//   HCLK, HRESETN                     clock, synchronous active-low reset
//   cmd_valid/cmd_ready               command handshake (ready only when idle)
//   cmd_write, cmd_addr, cmd_len      direction, byte address, 00/01/10/11 = 1/4/8/16 beats
//   wr_valid/wr_ready/wr_data         write beat stream into the staging buffer
//   rd_valid/rd_data                  read beat stream out, one cycle per beat
//   done, err                         end-of-command pulse and its error qualifier
//   HADDR..HWDATA                     AHB-Lite master outputs
//   HRDATA, HREADY, HRESP             AHB-Lite master inputs

module ahb_burst_master #(
  parameter int BUF_DEPTH = 16,
  parameter int RD_PIPE   = 0
) (
  input  logic        HCLK,
  input  logic        HRESETN,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [1:0]  cmd_len,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [31:0] wr_data,
  output logic        rd_valid,
  output logic [31:0] rd_data,
  output logic        done,
  output logic        err,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic [1:0]  HRESP
);

  localparam int PW = $clog2(BUF_DEPTH);

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_BUSY   = 2'b01;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ADDR, S_BURST, S_LAST, S_ERR1, S_ERR2
  } state_e;

  state_e        state_q;
  logic          cmd_ready_q, wr_ready_q, done_q, err_q;
  logic [31:0]   haddr_q, hwdata_q;
  logic [1:0]    htrans_q;
  logic          hwrite_q;
  logic [2:0]    hburst_q;
  logic [4:0]    len_q;       // beats in the burst (1/4/8/16)
  logic [4:0]    wr_cnt_q;    // beats taken into the buffer
  logic [4:0]    issued_q;    // address phases accepted by the bus
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic          dp_valid_q;  // a NONSEQ/SEQ data phase is in progress
  logic [31:0]   buf_q [BUF_DEPTH];

  logic          cmd_fire, wr_fire, addr_fire, bus_err, rd_fire;
  logic [4:0]    wr_cnt_d;
  logic [4:0]    len_d;
  logic [2:0]    hburst_d;
  logic          avail_next, avail_cur, load_go;
  logic          unused_addr_bits;

  assign cmd_fire  = cmd_valid & cmd_ready_q;
  assign wr_fire   = wr_valid & wr_ready_q;
  assign wr_cnt_d  = wr_cnt_q + {4'b0, wr_fire};
  assign addr_fire = HREADY & htrans_q[1];
  // First cycle of the two-cycle error response; the pending address is cancelled.
  assign bus_err   = dp_valid_q & ~HREADY & (HRESP != 2'b00);
  assign rd_fire   = dp_valid_q & ~hwrite_q & HREADY & (HRESP == 2'b00);
  assign unused_addr_bits = ^cmd_addr[1:0];

  always_comb begin
    len_d    = 5'd1;
    hburst_d = 3'b000;
    case (cmd_len)
      2'b01:   begin len_d = 5'd4;  hburst_d = 3'b011; end
      2'b10:   begin len_d = 5'd8;  hburst_d = 3'b101; end
      2'b11:   begin len_d = 5'd16; hburst_d = 3'b111; end
      default: begin len_d = 5'd1;  hburst_d = 3'b000; end
    endcase
  end

  // avail_next: data for the beat after the one being accepted is buffered.
  // avail_cur:  data for the beat held under BUSY has arrived.
`ifdef AHBM_BUSY_EN
  assign avail_next = !hwrite_q || (wr_cnt_d > (issued_q + 5'd1));
  assign avail_cur  = !hwrite_q || (wr_cnt_d > issued_q);
  assign load_go    = (wr_cnt_d != 5'd0);
`else
  assign avail_next = 1'b1;
  assign avail_cur  = 1'b1;
  assign load_go    = (wr_cnt_d == len_q);
`endif

  always_ff @(posedge HCLK) begin
    if (wr_fire) buf_q[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETN) begin
      state_q     <= S_IDLE;
      cmd_ready_q <= 1'b1;
      wr_ready_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      haddr_q     <= 32'd0;
      htrans_q    <= TR_IDLE;
      hwrite_q    <= 1'b0;
      hburst_q    <= 3'b000;
      hwdata_q    <= 32'd0;
      len_q       <= 5'd0;
      wr_cnt_q    <= 5'd0;
      issued_q    <= 5'd0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      dp_valid_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;

      if (wr_fire) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
        wr_cnt_q <= wr_cnt_d;
        if (wr_cnt_d == len_q) wr_ready_q <= 1'b0;
      end

      if (HREADY) dp_valid_q <= addr_fire;

      // Write data for a beat is fetched as its address phase is accepted,
      // so it sits on HWDATA for the whole data phase including wait states.
      if (addr_fire) begin
        issued_q <= issued_q + 5'd1;
        if (hwrite_q) begin
          hwdata_q <= buf_q[rd_ptr_q];
          rd_ptr_q <= rd_ptr_q + PW'(1);
        end
      end

      case (state_q)
        S_IDLE: begin
          if (cmd_fire) begin
            cmd_ready_q <= 1'b0;
            haddr_q     <= {cmd_addr[31:2], 2'b00};
            hwrite_q    <= cmd_write;
            hburst_q    <= hburst_d;
            len_q       <= len_d;
            wr_cnt_q    <= 5'd0;
            issued_q    <= 5'd0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            if (cmd_write) begin
              wr_ready_q <= 1'b1;
              state_q    <= S_LOAD;
            end else begin
              htrans_q   <= TR_NONSEQ;
              state_q    <= S_ADDR;
            end
          end
        end

        S_LOAD: begin
          if (load_go) begin
            htrans_q <= TR_NONSEQ;
            state_q  <= S_ADDR;
          end
        end

        S_ADDR: begin
          if (HREADY) begin
            if (len_q == 5'd1) begin
              htrans_q <= TR_IDLE;
              state_q  <= S_LAST;
            end else begin
              haddr_q  <= haddr_q + 32'd4;
              htrans_q <= avail_next ? TR_SEQ : TR_BUSY;
              state_q  <= S_BURST;
            end
          end
        end

        S_BURST: begin
          if (bus_err) begin
            htrans_q   <= TR_IDLE;
            dp_valid_q <= 1'b0;
            wr_ready_q <= 1'b0;
            state_q    <= S_ERR1;
          end else if (HREADY) begin
            if (htrans_q == TR_BUSY) begin
              if (avail_cur) htrans_q <= TR_SEQ;
            end else if (issued_q == len_q - 5'd1) begin
              htrans_q <= TR_IDLE;
              state_q  <= S_LAST;
            end else begin
              haddr_q  <= haddr_q + 32'd4;
              htrans_q <= avail_next ? TR_SEQ : TR_BUSY;
            end
          end
        end

        S_LAST: begin
          if (bus_err) begin
            dp_valid_q <= 1'b0;
            wr_ready_q <= 1'b0;
            state_q    <= S_ERR1;
          end else if (HREADY) begin
            done_q      <= 1'b1;
            cmd_ready_q <= 1'b1;
            wr_ready_q  <= 1'b0;
            state_q     <= S_IDLE;
          end
        end

        S_ERR1: state_q <= S_ERR2;

        S_ERR2: begin
          if (HREADY) begin
            done_q      <= 1'b1;
            err_q       <= 1'b1;
            cmd_ready_q <= 1'b1;
            wr_ready_q  <= 1'b0;
            wr_cnt_q    <= 5'd0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            state_q     <= S_IDLE;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  generate
    if (RD_PIPE != 0) begin : g_rd_pipe
      logic        rd_valid_q;
      logic [31:0] rd_data_q;
      always_ff @(posedge HCLK) begin
        if (!HRESETN) begin
          rd_valid_q <= 1'b0;
          rd_data_q  <= 32'd0;
        end else begin
          rd_valid_q <= rd_fire;
          rd_data_q  <= HRDATA;
        end
      end
      assign rd_valid = rd_valid_q;
      assign rd_data  = rd_data_q;
    end else begin : g_rd_comb
      assign rd_valid = rd_fire;
      assign rd_data  = HRDATA;
    end
  endgenerate

  assign cmd_ready = cmd_ready_q;
  assign wr_ready  = wr_ready_q;
  assign done      = done_q;
  assign err       = err_q;
  assign HADDR     = haddr_q;
  assign HTRANS    = htrans_q;
  assign HWRITE    = hwrite_q;
  assign HSIZE     = 3'b010;
  assign HBURST    = hburst_q;
  assign HWDATA    = hwdata_q;

endmodule

// File: tb/tb_ahb_burst_master.sv
// tb/tb_ahb_burst_master.sv - directed self-checking bench for ahb_burst_master

module tb_ahb_burst_master;

  logic        HCLK = 1'b0;
  logic        HRESETN = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [31:0] cmd_addr = 32'd0;
  logic [1:0]  cmd_len = 2'b00;
  logic        wr_valid = 1'b0, wr_ready;
  logic [31:0] wr_data = 32'd0;
  logic        rd_valid, done, err;
  logic [31:0] rd_data;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS, HRESP;
  logic        HWRITE, HREADY;
  logic [2:0]  HSIZE, HBURST;

  ahb_burst_master dut (
    .HCLK(HCLK), .HRESETN(HRESETN),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_data(rd_data), .done(done), .err(err),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY),
    .HRESP(HRESP)
  );

  initial forever #5 HCLK = ~HCLK;

  int cyc = 0;
  initial forever begin
    @(posedge HCLK);
    cyc++;
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- slave model and monitor ----------------
  logic        s_dp = 1'b0;
  logic [31:0] s_dp_addr = 32'd0;
  logic        s_dp_wr = 1'b0;
  int          s_dp_beat = 0;
  int          s_nbeat = 0;
  int          err_beat = -1, wait_beat = -1, waits_left = 0, err_stage = 0;
  logic [31:0] addr_log [32];
  logic [1:0]  trans_log [32];
  logic [2:0]  burst_log [32];
  logic [2:0]  size_log [32];
  logic [31:0] wdata_log [32];
  logic [31:0] rd_log [32];
  int          rd_n = 0, busy_n = 0, hold_viol = 0, done_cyc = 0;
  logic [31:0] busy_addr = 32'd0, hold_addr = 32'd0, hold_wdata = 32'd0;
  logic        hold_arm = 1'b0, done_seen = 1'b0, done_err = 1'b0;
  logic [1:0]  trans_after_err = 2'b11;

  function automatic logic [31:0] rd_pat(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic slave_arm(input int eb, input int wb, input int wn);
    s_nbeat = 0; rd_n = 0; busy_n = 0; hold_viol = 0; hold_arm = 1'b0;
    done_seen = 1'b0; done_err = 1'b0; err_stage = 0; trans_after_err = 2'b11;
    err_beat = eb; wait_beat = wb; waits_left = wn;
  endtask

  initial begin
    logic hr;
    logic [1:0] rsp;
    HREADY = 1'b1; HRESP = 2'b00; HRDATA = 32'd0;
    forever begin
      @(negedge HCLK);
      hr = 1'b1; rsp = 2'b00;
      if (s_dp) begin
        if (s_dp_beat == err_beat && err_stage == 0) begin
          hr = 1'b0; rsp = 2'b01; err_stage = 1;
        end else if (err_stage == 1) begin
          hr = 1'b1; rsp = 2'b01; err_stage = 2; trans_after_err = HTRANS;
        end else if (s_dp_beat == wait_beat && waits_left > 0) begin
          hr = 1'b0; waits_left--;
          if (!hold_arm) begin
            hold_arm = 1'b1; hold_addr = HADDR; hold_wdata = HWDATA;
          end else if (HADDR !== hold_addr || HWDATA !== hold_wdata) hold_viol++;
        end else begin
          if (hold_arm) begin
            if (HADDR !== hold_addr || HWDATA !== hold_wdata) hold_viol++;
            hold_arm = 1'b0;
          end
          if (s_dp_wr) wdata_log[s_dp_beat] = HWDATA;
          else HRDATA = rd_pat(s_dp_addr);
        end
      end
      HREADY = hr; HRESP = rsp;
      if (!HRESETN) s_dp = 1'b0;
      else if (hr) begin
        s_dp = HTRANS[1];
        if (HTRANS[1] && s_nbeat < 32) begin
          addr_log[s_nbeat] = HADDR; trans_log[s_nbeat] = HTRANS;
          burst_log[s_nbeat] = HBURST; size_log[s_nbeat] = HSIZE;
          s_dp_addr = HADDR; s_dp_wr = HWRITE; s_dp_beat = s_nbeat;
          s_nbeat++;
        end else if (HTRANS == 2'b01) begin
          busy_n++; busy_addr = HADDR;
        end
      end
      #1;
      if (rd_valid && rd_n < 32) begin rd_log[rd_n] = rd_data; rd_n++; end
      if (done && !done_seen) begin done_seen = 1'b1; done_err = err; done_cyc = cyc; end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic issue(input string tag, input logic w, input logic [31:0] a,
                       input logic [1:0] l, output int acc);
    int k;
    @(negedge HCLK);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = l;
    k = 0;
    while (!cmd_ready && k < 50) begin @(negedge HCLK); k++; end
    expect_eq({tag, "_accept"}, cmd_ready, 1'b1);
    @(posedge HCLK); #1;
    acc = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic feed(input string tag, input int n, input logic [31:0] first,
                      input int gap_idx, input int gap_len);
    int k;
    for (int i = 0; i < n; i++) begin
      if (i == gap_idx) repeat (gap_len) @(negedge HCLK);
      @(negedge HCLK);
      wr_valid = 1'b1; wr_data = (first == 32'hDEADBEEF) ? first : first + i;
      k = 0;
      while (!wr_ready && k < 50) begin @(negedge HCLK); k++; end
      expect_eq($sformatf("%s_wr%0d", tag, i), wr_ready, 1'b1);
      @(posedge HCLK); #1;
      wr_valid = 1'b0;
    end
  endtask

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while (!done_seen && k < 200) begin @(negedge HCLK); #2; k++; end
    expect_eq({tag, "_done"}, done_seen, 1'b1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  // ---------------- directed tests ----------------
  initial begin
    int acc;
    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    expect_eq("rst_htrans", HTRANS, 2'b00);
    expect_eq("rst_haddr", HADDR, 32'd0);
    expect_eq("rst_hwrite", HWRITE, 1'b0);
    expect_eq("rst_hburst", HBURST, 3'b000);
    expect_eq("rst_hwdata", HWDATA, 32'd0);
    expect_eq("rst_hsize", HSIZE, 3'b010);
    expect_eq("rst_cmd_ready", cmd_ready, 1'b1);
    expect_eq("rst_wr_ready", wr_ready, 1'b0);
    expect_eq("rst_rd_valid", rd_valid, 1'b0);
    expect_eq("rst_done", done, 1'b0);
    expect_eq("rst_err", err, 1'b0);
    HRESETN = 1'b1;
    repeat (2) @(negedge HCLK);

    // 1: read INCR4 @0x100, zero wait
    slave_arm(-1, -1, 0);
    issue("t1", 1'b0, 32'h100, 2'b01, acc);
    wait_done("t1");
    expect_eq("t1_latency", done_cyc - acc + 1, 6);
    expect_eq("t1_err", done_err, 1'b0);
    expect_eq("t1_nbeat", s_nbeat, 4);
    expect_eq("t1_rd_n", rd_n, 4);
    expect_eq("t1_hburst", burst_log[0], 3'b011);
    for (int i = 0; i < 4; i++) begin
      expect_eq($sformatf("t1_addr%0d", i), addr_log[i], 32'h100 + 4 * i);
      expect_eq($sformatf("t1_trans%0d", i), trans_log[i], (i == 0) ? 2'b10 : 2'b11);
      expect_eq($sformatf("t1_rd%0d", i), rd_log[i], rd_pat(32'h100 + 4 * i));
    end

    // 2: write INCR8 @0x200, data 1..8, two wait states on beat 3
    slave_arm(-1, 2, 2);
    issue("t2", 1'b1, 32'h200, 2'b10, acc);
    feed("t2", 8, 32'd1, -1, 0);
    wait_done("t2");
    expect_eq("t2_err", done_err, 1'b0);
    expect_eq("t2_nbeat", s_nbeat, 8);
    expect_eq("t2_hburst", burst_log[0], 3'b101);
    expect_eq("t2_hold_viol", hold_viol, 0);
    expect_eq("t2_hold_addr", hold_addr, 32'h20C);
    expect_eq("t2_hold_wdata", hold_wdata, 32'd3);
    for (int i = 0; i < 8; i++) begin
      expect_eq($sformatf("t2_addr%0d", i), addr_log[i], 32'h200 + 4 * i);
      expect_eq($sformatf("t2_wdata%0d", i), wdata_log[i], i + 1);
    end

    // 3: read INCR16 @0x3C0, ERROR on beat 5, then SINGLE read @0x0
    slave_arm(4, -1, 0);
    issue("t3", 1'b0, 32'h3C0, 2'b11, acc);
    wait_done("t3");
    expect_eq("t3_err", done_err, 1'b1);
    expect_eq("t3_trans_after_err", trans_after_err, 2'b00);
    expect_eq("t3_rd_n", rd_n, 4);
    expect_eq("t3_nbeat", s_nbeat, 5);
    for (int i = 0; i < 4; i++)
      expect_eq($sformatf("t3_rd%0d", i), rd_log[i], rd_pat(32'h3C0 + 4 * i));
    slave_arm(-1, -1, 0);
    issue("t3s", 1'b0, 32'h0, 2'b00, acc);
    wait_done("t3s");
    expect_eq("t3s_err", done_err, 1'b0);
    expect_eq("t3s_rd_n", rd_n, 1);
    expect_eq("t3s_rd0", rd_log[0], 32'hA5A5_0000);
    expect_eq("t3s_hburst", burst_log[0], 3'b000);
    expect_eq("t3s_trans", trans_log[0], 2'b10);

    // 4: SINGLE write 0xDEADBEEF, cmd_addr 0x7
    slave_arm(-1, -1, 0);
    issue("t4", 1'b1, 32'h7, 2'b00, acc);
    feed("t4", 1, 32'hDEADBEEF, -1, 0);
    wait_done("t4");
    expect_eq("t4_err", done_err, 1'b0);
    expect_eq("t4_nbeat", s_nbeat, 1);
    expect_eq("t4_haddr", addr_log[0], 32'h4);
    expect_eq("t4_hburst", burst_log[0], 3'b000);
    expect_eq("t4_hsize", size_log[0], 3'b010);
    expect_eq("t4_wdata", wdata_log[0], 32'hDEADBEEF);

    // 5: reset during beat 2 of an INCR8 write
    slave_arm(-1, -1, 0);
    issue("t5", 1'b1, 32'h300, 2'b10, acc);
    feed("t5", 8, 32'h50, -1, 0);
    begin
      int k;
      k = 0;
      while (s_nbeat < 2 && k < 50) begin @(negedge HCLK); #2; k++; end
      expect_eq("t5_reached_beat2", s_nbeat >= 2, 1'b1);
    end
    HRESETN = 1'b0;
    @(posedge HCLK); #1;
    expect_eq("t5_htrans", HTRANS, 2'b00);
    expect_eq("t5_cmd_ready", cmd_ready, 1'b1);
    expect_eq("t5_wr_ready", wr_ready, 1'b0);
    @(negedge HCLK);
    HRESETN = 1'b1;
    repeat (20) @(negedge HCLK);
    #2;
    expect_eq("t5_no_done", done_seen, 1'b0);
    expect_eq("t5_idle_after", HTRANS, 2'b00);

`ifdef AHBM_BUSY_EN
    // 6: INCR4 write with a 3-cycle gap before beat 3 -> BUSY at 0x208
    slave_arm(-1, -1, 0);
    issue("t6", 1'b1, 32'h200, 2'b01, acc);
    feed("t6", 4, 32'd1, 2, 3);
    wait_done("t6");
    expect_eq("t6_err", done_err, 1'b0);
    expect_eq("t6_busy_seen", busy_n > 0, 1'b1);
    expect_eq("t6_busy_addr", busy_addr, 32'h208);
    expect_eq("t6_nbeat", s_nbeat, 4);
    for (int i = 0; i < 4; i++) begin
      expect_eq($sformatf("t6_addr%0d", i), addr_log[i], 32'h200 + 4 * i);
      expect_eq($sformatf("t6_wdata%0d", i), wdata_log[i], i + 1);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
